// File: rtl/monobit_pkg.sv
// rtl/monobit_pkg.sv - shared state encoding, mode constants and width helpers for the monobit tester
package monobit_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    EVAL = 2'd2,
    DONE = 2'd3
  } state_e;

  localparam logic MODE_MONO  = 1'b0;
  localparam logic MODE_BLOCK = 1'b1;

  // ones_count must reach N without wrapping
  function automatic int ones_w(input int log2_n);
    return log2_n + 1;
  endfunction

  function automatic int bad_w(input int log2_n, input int log2_m);
    return log2_n - log2_m + 1;
  endfunction

  // |2*ones - N| lives in 0..N, one extra bit keeps 2*ones representable
  function automatic int s_w(input int log2_n);
    return log2_n + 2;
  endfunction

endpackage

// File: rtl/monobit_freq_tester_if.sv
// rtl/monobit_freq_tester_if.sv - control, stream and result bundle of the tester
// Optional runs ports appear when MONOBIT_RUNS_EN is defined.
interface monobit_freq_tester_if
  import monobit_pkg::*;
#(
  parameter int LOG2_N = 7,
  parameter int LOG2_M = 4,
  parameter int THR_W  = 8
);

  logic                           start;
  logic                           mode;
  logic [THR_W-1:0]               threshold;
  logic [LOG2_M:0]                blk_thr;
  logic                           bit_in;
  logic                           bit_valid;
  logic                           busy;
  logic                           done;
  logic                           pass;
  logic [ones_w(LOG2_N)-1:0]      ones_count;
  logic [bad_w(LOG2_N,LOG2_M)-1:0] bad_blocks;
`ifdef MONOBIT_RUNS_EN
  logic [LOG2_N:0]                runs_count;
  logic [LOG2_N:0]                runs_min;
`endif

  modport master (
`ifdef MONOBIT_RUNS_EN
    output runs_min,
    input  runs_count,
`endif
    output start, mode, threshold, blk_thr, bit_in, bit_valid,
    input  busy, done, pass, ones_count, bad_blocks
  );

  modport slave (
`ifdef MONOBIT_RUNS_EN
    input  runs_min,
    output runs_count,
`endif
    input  start, mode, threshold, blk_thr, bit_in, bit_valid,
    output busy, done, pass, ones_count, bad_blocks
  );

endinterface

// File: rtl/monobit_block_counter.sv
// rtl/monobit_block_counter.sv - per-sub-block ones counter with deviation check
// blk_bad is combinational so the final block of a window is counted on the same edge as its last bit.
module monobit_block_counter
  import monobit_pkg::*;
#(
  parameter int LOG2_M = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            clear,
  input  logic            bit_take,
  input  logic            bit_in,
  input  logic            blk_end,
  input  logic [LOG2_M:0] blk_thr,
  output logic            blk_bad
);

  localparam int DW = LOG2_M + 2;
  localparam logic [DW-1:0] M_VAL = DW'(2 ** LOG2_M);

  logic [LOG2_M-1:0] cnt_q, cnt_d;
  logic [DW-1:0]     twice, dev;

  always_comb begin
    twice   = ({2'b00, cnt_q} + DW'(bit_in)) << 1;
    dev     = (twice >= M_VAL) ? (twice - M_VAL) : (M_VAL - twice);
    blk_bad = bit_take && blk_end && (dev > {1'b0, blk_thr});

    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (bit_take) begin
      cnt_d = blk_end ? '0 : cnt_q + LOG2_M'(bit_in);
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/monobit_freq_tester.sv
// rtl/monobit_freq_tester.sv - windowed monobit / block-frequency tester top
// MONOBIT_RUNS_EN adds a runs counter that also gates the verdict.
module monobit_freq_tester
  import monobit_pkg::*;
#(
  parameter int LOG2_N = 7,
  parameter int LOG2_M = 4,
  parameter int THR_W  = 8
) (
  input logic                  clk,
  input logic                  rst_n,
  monobit_freq_tester_if.slave bus
);

  localparam int OW   = ones_w(LOG2_N);
  localparam int BW   = bad_w(LOG2_N, LOG2_M);
  localparam int SW   = s_w(LOG2_N);
  localparam int CW_S = (SW > THR_W) ? SW : THR_W;
  localparam int CW_B = (BW > THR_W) ? BW : THR_W;
  localparam logic [SW-1:0] N_VAL = SW'(2 ** LOG2_N);

  state_e              state_q, state_d;
  logic                mode_q, mode_d;
  logic [THR_W-1:0]    thr_q, thr_d;
  logic [LOG2_M:0]     blk_thr_q, blk_thr_d;
  logic [LOG2_N-1:0]   idx_q, idx_d;
  logic [OW-1:0]       ones_q, ones_d;
  logic [BW-1:0]       bad_q, bad_d;
  logic                pass_q, pass_d;
  logic                done_q, done_d;

  logic                start_acc, bit_take, blk_end, blk_bad;
  logic [SW-1:0]       twice_ones, s_mag;
  logic                pass_eval;

`ifdef MONOBIT_RUNS_EN
  logic [LOG2_N:0]     runs_q, runs_d;
  logic [LOG2_N:0]     runs_min_q, runs_min_d;
  logic                prev_q, prev_d;
`endif

  assign start_acc = bus.start && ((state_q == IDLE) || (state_q == DONE));
  assign bit_take  = bus.bit_valid && (state_q == RUN);
  assign blk_end   = &idx_q[LOG2_M-1:0];

  monobit_block_counter #(.LOG2_M(LOG2_M)) u_blk (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear    (start_acc),
    .bit_take (bit_take),
    .bit_in   (bus.bit_in),
    .blk_end  (blk_end),
    .blk_thr  (blk_thr_q),
    .blk_bad  (blk_bad)
  );

  always_comb begin
    twice_ones = {ones_q, 1'b0};
    s_mag      = (twice_ones >= N_VAL) ? (twice_ones - N_VAL) : (N_VAL - twice_ones);
    if (mode_q == MODE_MONO) begin
      pass_eval = CW_S'(s_mag) <= CW_S'(thr_q);
    end else begin
      pass_eval = CW_B'(bad_q) <= CW_B'(thr_q);
    end
`ifdef MONOBIT_RUNS_EN
    pass_eval = pass_eval && (runs_q >= runs_min_q);
`endif
  end

  always_comb begin
    state_d   = state_q;
    mode_d    = mode_q;
    thr_d     = thr_q;
    blk_thr_d = blk_thr_q;
    idx_d     = idx_q;
    ones_d    = ones_q;
    bad_d     = bad_q;
    pass_d    = pass_q;
    // done trails the DONE state by one cycle and drops on the restart edge
    done_d    = (state_q == DONE) && !start_acc;
`ifdef MONOBIT_RUNS_EN
    runs_d     = runs_q;
    runs_min_d = runs_min_q;
    prev_d     = prev_q;
`endif

    case (state_q)
      IDLE, DONE: begin
        if (bus.start) begin
          state_d   = RUN;
          mode_d    = bus.mode;
          thr_d     = bus.threshold;
          blk_thr_d = bus.blk_thr;
          idx_d     = '0;
          ones_d    = '0;
          bad_d     = '0;
          pass_d    = 1'b0;
`ifdef MONOBIT_RUNS_EN
          runs_d     = '0;
          runs_min_d = bus.runs_min;
`endif
        end
      end
      RUN: begin
        if (bus.bit_valid) begin
          idx_d  = idx_q + 1'b1;
          ones_d = ones_q + OW'(bus.bit_in);
          bad_d  = bad_q + BW'(blk_bad);
`ifdef MONOBIT_RUNS_EN
          prev_d = bus.bit_in;
          if (runs_q == '0) begin
            runs_d = (LOG2_N+1)'(1);
          end else if (bus.bit_in != prev_q) begin
            runs_d = runs_q + 1'b1;
          end
`endif
          if (&idx_q) begin
            state_d = EVAL;
          end
        end
      end
      EVAL: begin
        pass_d  = pass_eval;
        state_d = DONE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      state_q   <= IDLE;
      mode_q    <= 1'b0;
      thr_q     <= '0;
      blk_thr_q <= '0;
      idx_q     <= '0;
      ones_q    <= '0;
      bad_q     <= '0;
      pass_q    <= 1'b0;
      done_q    <= 1'b0;
`ifdef MONOBIT_RUNS_EN
      runs_q     <= '0;
      runs_min_q <= '0;
      prev_q     <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      mode_q    <= mode_d;
      thr_q     <= thr_d;
      blk_thr_q <= blk_thr_d;
      idx_q     <= idx_d;
      ones_q    <= ones_d;
      bad_q     <= bad_d;
      pass_q    <= pass_d;
      done_q    <= done_d;
`ifdef MONOBIT_RUNS_EN
      runs_q     <= runs_d;
      runs_min_q <= runs_min_d;
      prev_q     <= prev_d;
`endif
    end
  end

  assign bus.busy       = (state_q == RUN) || (state_q == EVAL);
  assign bus.done       = done_q;
  assign bus.pass       = pass_q;
  assign bus.ones_count = ones_q;
  assign bus.bad_blocks = bad_q;
`ifdef MONOBIT_RUNS_EN
  assign bus.runs_count = runs_q;
`endif

endmodule

// File: tb/tb_monobit_freq_tester.sv
// tb/tb_monobit_freq_tester.sv - directed and random windows checked against an arithmetic reference
module tb_monobit_freq_tester;
  import monobit_pkg::*;

  localparam int LOG2_N = 7;
  localparam int LOG2_M = 4;
  localparam int THR_W  = 8;
  localparam int N      = 128;
  localparam int M      = 16;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  monobit_freq_tester_if #(.LOG2_N(LOG2_N), .LOG2_M(LOG2_M), .THR_W(THR_W)) bus ();

  monobit_freq_tester #(.LOG2_N(LOG2_N), .LOG2_M(LOG2_M), .THR_W(THR_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  int total = 0;
  int bad   = 0;
  bit win [N];
  int exp_ones, exp_bad, exp_runs;
  bit exp_pass;
  bit cur_mode;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  function automatic void model(input bit m, input int thr, input int bthr, input int rmin);
    int s, bo, dv;
    exp_ones = 0;
    exp_bad  = 0;
    exp_runs = 1;
    foreach (win[i]) exp_ones += int'(win[i]);
    for (int i = 1; i < N; i++) if (win[i] != win[i-1]) exp_runs++;
    s = 2 * exp_ones - N;
    if (s < 0) s = -s;
    for (int b = 0; b < N / M; b++) begin
      bo = 0;
      for (int j = 0; j < M; j++) bo += int'(win[b*M + j]);
      dv = 2 * bo - M;
      if (dv < 0) dv = -dv;
      if (dv > bthr) exp_bad++;
    end
    exp_pass = m ? (exp_bad <= thr) : (s <= thr);
`ifdef MONOBIT_RUNS_EN
    exp_pass = exp_pass && (exp_runs >= rmin);
`endif
  endfunction

  task automatic do_start(input bit m, input int thr, input int bthr, input int rmin);
    bus.start     = 1'b1;
    bus.mode      = m;
    bus.threshold = THR_W'(thr);
    bus.blk_thr   = (LOG2_M+1)'(bthr);
    bus.bit_valid = 1'b1;
    bus.bit_in    = 1'b1;
`ifdef MONOBIT_RUNS_EN
    bus.runs_min  = (LOG2_N+1)'(rmin);
`endif
    cur_mode = m;
    tick();
    bus.start     = 1'b0;
    bus.bit_valid = 1'b0;
    chk("start_busy", 32'(bus.busy), 32'd1);
    chk("start_done", 32'(bus.done), 32'd0);
    chk("start_ones", 32'(bus.ones_count), 32'd0);
    model(m, thr, bthr, rmin);
  endtask

  task automatic send_window(input int gap_pct, input bit poke);
    for (int i = 0; i < N; i++) begin
      for (int g = 0; g < 4 && int'($urandom_range(99)) < gap_pct; g++) begin
        bus.bit_valid = 1'b0;
        bus.bit_in    = 1'($urandom_range(1));
        if (poke) begin
          bus.start     = 1'b1;
          bus.mode      = ~cur_mode;
          bus.threshold = THR_W'($urandom_range(255));
          bus.blk_thr   = (LOG2_M+1)'($urandom_range(31));
        end
        tick();
        bus.start = 1'b0;
      end
      bus.bit_valid = 1'b1;
      bus.bit_in    = win[i];
      tick();
    end
    bus.bit_valid = 1'b0;
    chk("lat_k_done", 32'(bus.done), 32'd0);
    chk("lat_k_busy", 32'(bus.busy), 32'd1);
    tick();
    chk("lat_k1_done", 32'(bus.done), 32'd0);
    tick();
    chk("lat_k2_done", 32'(bus.done), 32'd1);
  endtask

  task automatic check_results(input string tag);
    chk({tag, "_ones"}, 32'(bus.ones_count), 32'(exp_ones));
    chk({tag, "_bad"}, 32'(bus.bad_blocks), 32'(exp_bad));
    chk({tag, "_pass"}, 32'(bus.pass), 32'(exp_pass));
`ifdef MONOBIT_RUNS_EN
    chk({tag, "_runs"}, 32'(bus.runs_count), 32'(exp_runs));
`endif
  endtask

  task automatic fill_ones(input int k);
    int j;
    bit t;
    for (int i = 0; i < N; i++) win[i] = (i < k);
    for (int i = N - 1; i > 0; i--) begin
      j = int'($urandom_range(i));
      t = win[i]; win[i] = win[j]; win[j] = t;
    end
  endtask

  initial begin
    bus.start     = 1'b0;
    bus.mode      = 1'b0;
    bus.threshold = '0;
    bus.blk_thr   = '0;
    bus.bit_in    = 1'b0;
    bus.bit_valid = 1'b0;
`ifdef MONOBIT_RUNS_EN
    bus.runs_min  = '0;
`endif
    rst_n = 1'b1;
    tick();
    tick();
    rst_n = 1'b0;
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_done", 32'(bus.done), 32'd0);
    chk("rst_pass", 32'(bus.pass), 32'd0);
    chk("rst_ones", 32'(bus.ones_count), 32'd0);
    chk("rst_bad", 32'(bus.bad_blocks), 32'd0);

    // alternating window, exact balance
    for (int i = 0; i < N; i++) win[i] = i[0];
    do_start(MODE_MONO, 0, 4, 0);
    send_window(0, 1'b0);
    check_results("alt");

    // all ones
    for (int i = 0; i < N; i++) win[i] = 1'b1;
    do_start(MODE_MONO, 20, 4, 0);
    send_window(0, 1'b0);
    check_results("ones");

    // threshold boundary S = 20 then S = 22, restarting from DONE
    fill_ones(74);
    do_start(MODE_MONO, 20, 4, 0);
    send_window(0, 1'b0);
    check_results("s20");
    bus.bit_valid = 1'b1;
    bus.bit_in    = 1'b1;
    tick();
    tick();
    bus.bit_valid = 1'b0;
    chk("hold_ones", 32'(bus.ones_count), 32'(exp_ones));
    chk("hold_done", 32'(bus.done), 32'd1);
    fill_ones(75);
    do_start(MODE_MONO, 20, 4, 0);
    chk("restart_pass", 32'(bus.pass), 32'd0);
    send_window(0, 1'b0);
    check_results("s22");

    // block mode: six balanced blocks, two empty ones
    for (int b = 0; b < N / M; b++)
      for (int j = 0; j < M; j++)
        win[b*M + j] = (b == 2 || b == 5) ? 1'b0 : j[0];
    do_start(MODE_BLOCK, 1, 4, 0);
    send_window(0, 1'b0);
    check_results("blk_t1");
    do_start(MODE_BLOCK, 2, 4, 0);
    send_window(0, 1'b0);
    check_results("blk_t2");

    // stalls plus ignored start pulses
    fill_ones(74);
    do_start(MODE_MONO, 20, 4, 0);
    send_window(50, 1'b1);
    check_results("gaps");

    // reset in the middle of a run
    for (int i = 0; i < N; i++) win[i] = 1'($urandom_range(1));
    do_start(MODE_MONO, 10, 4, 0);
    for (int i = 0; i < 60; i++) begin
      bus.bit_valid = 1'b1;
      bus.bit_in    = win[i];
      tick();
    end
    bus.bit_valid = 1'b0;
    rst_n = 1'b1;
    tick();
    rst_n = 1'b0;
    chk("mid_rst_busy", 32'(bus.busy), 32'd0);
    chk("mid_rst_done", 32'(bus.done), 32'd0);
    chk("mid_rst_ones", 32'(bus.ones_count), 32'd0);
    chk("mid_rst_bad", 32'(bus.bad_blocks), 32'd0);
    tick();
    chk("mid_rst_idle", 32'(bus.busy), 32'd0);
    for (int i = 0; i < N; i++) win[i] = i[0];
    do_start(MODE_MONO, 0, 4, 0);
    send_window(0, 1'b0);
    check_results("post_rst");

    // random windows with random configuration
    for (int r = 0; r < 8; r++) begin
      int k;
      k = int'($urandom_range(N));
      fill_ones(k);
      do_start(1'($urandom_range(1)), int'($urandom_range(40)), int'($urandom_range(16)),
               int'($urandom_range(80)));
      send_window(30, 1'b0);
      check_results($sformatf("rnd%0d", r));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/monobit_freq_tester.md
Name: monobit_freq_tester

Overview:
Parametrised successor to the single-window monobit test core. It consumes a serial bit stream with a valid strobe over a window of N = 2^LOG2_N bits and evaluates one of two modes, selected per run:
- Mode 0: NIST-style frequency (monobit) test.
- Mode 1: block-frequency test over M = 2^LOG2_M-bit sub-blocks.

It sits behind the tt_um top-level IO mux, with results read out on dedicated outputs.

Parameters:
LOG2_N, 7, log2 of window length; N = 128 bits by default.
LOG2_M, 4, log2 of sub-block length; M = 16 bits. Must satisfy LOG2_M < LOG2_N.
THR_W, 8, width of the pass threshold input.

Ports:
clk  in  1  system clock; all logic on rising edge.
rst_n  in  1  synchronous, active-high reset. The name is kept for harness compatibility; the polarity is high.
start  in  1  begin a run. Accepted in IDLE or DONE only.
mode  in  1  0 = monobit, 1 = block-frequency. Latched on start.
threshold  in  THR_W  pass limit. Mode 0 limit is on S; mode 1 limit is on bad_blocks. Latched on start.
blk_thr  in  LOG2_M+1  per-block deviation limit. Latched on start.
bit_in  in  1  stream bit.
bit_valid  in  1  bit_in is consumed when high during RUN.
busy  out  1  high in RUN and EVAL.
done  out  1  high in DONE.
pass  out  1  test verdict; valid while done = 1.
ones_count  out  LOG2_N+1  total ones seen in the window.
bad_blocks  out  LOG2_N-LOG2_M+1  count of sub-blocks exceeding blk_thr.

Behaviour:
- Reset (rst_n = 1 at an edge):
  - State goes to IDLE.
  - busy, done, pass, ones_count, bad_blocks, bit index and block counters are all cleared to 0.
  - Applies from any state. A partial run is discarded with no done pulse.
- FSM states: IDLE -> RUN -> EVAL -> DONE; DONE -> RUN on start.
- IDLE, or DONE with start = 1:
  - Next state is RUN.
  - Clear counters, done and pass.
  - Latch mode, threshold and blk_thr.
  - bit_valid in the start cycle is ignored.
- Start handling: start is ignored in RUN and EVAL, and the latched configuration is unchanged.
- RUN, on each edge with bit_valid = 1:
  - bit index increments.
  - ones_count increments if bit_in = 1.
  - The block ones counter increments if bit_in = 1.
- RUN, with bit_valid = 0: all counters hold (stall). There is no timeout.
- Sub-block end (bit index mod M = M-1 with a valid bit):
  - Compute d = |2*blk_ones - M| at LOG2_M+2 bits, including the current bit.
  - If d > blk_thr, bad_blocks increments.
  - The block counter resets to 0.
- Window end (bit index = N-1 with a valid bit): next state is EVAL. The bit index wraps to 0.
- EVAL lasts one cycle:
  - Compute S = |2*ones_count - N| at LOG2_N+2 bits signed, with magnitude 0..N.
  - Mode 0: pass = (S <= zero-extended threshold).
  - Mode 1: pass = (bad_blocks <= zero-extended threshold).
  - Next state is DONE.
- Latency: the last valid bit is sampled at edge k; done = 1 and pass are visible after edge k+2.
- DONE:
  - done, pass, ones_count and bad_blocks hold until the next start or reset.
  - bit_valid is ignored.
- Width rules:
  - ones_count reaches N without overflow.
  - If threshold is wider than S, compare with both operands zero-extended to a common width.
  - If threshold is narrower, zero-extend threshold.

Optional Feature:
Macro: MONOBIT_RUNS_EN.
- Defined:
  - Adds output runs_count [LOG2_N:0] and input runs_min [LOG2_N:0], latched on start.
  - runs_count = 1 + number of bit_in transitions between consecutive valid bits in the window. It is 0 before the first bit and cleared on start.
  - In EVAL, pass is additionally ANDed with (runs_count >= runs_min), in both modes.
- Undefined: these ports and the logic do not exist, and pass is as above.

Decomposition:
- Package monobit_pkg contains:
  - State enum: IDLE, RUN, EVAL, DONE.
  - Mode constants: MODE_MONO = 0, MODE_BLOCK = 1.
  - Width helper functions for ones_count, bad_blocks and S.
- Sub-module monobit_block_counter:
  - Holds the per-block ones counter and the deviation comparator.
  - Emits a one-cycle blk_bad pulse at each sub-block end.
  - Instantiated once.

Test Plan:
1. Mode 0, threshold = 0, 128 bits alternating 0101… -> ones_count = 64, S = 0, pass = 1; done rises 2 edges after the last bit.
2. Mode 0, threshold = 20, all-ones window -> ones_count = 128, S = 128, pass = 0.
3. Mode 0, threshold = 20: window with 74 ones -> S = 20, pass = 1; then restart from DONE with 75 ones -> S = 22, pass = 0.
4. Mode 1, blk_thr = 4, six balanced 16-bit blocks plus two all-zero blocks (N = 128) -> bad_blocks = 2, ones_count = 48. With threshold = 1, pass = 0; rerun with threshold = 2, pass = 1.
5. Random bit_valid gaps (~50% duty) during a run -> results identical to the gap-free run of scenario 3. start pulsed in RUN is ignored.
6. rst_n asserted after 60 valid bits -> next cycle all outputs are 0 and state is IDLE. A fresh start then yields correct results for scenario 1.
